// File: rtl/wb_fwd_if.sv
// Destination-bundle bypass bus between decode/execute datapath and the writeback pipe.
// The slave side is the pipe; the master side is whoever drives ID and the stage data.
interface wb_fwd_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              id_valid;
  logic              id_we;
  logic [ADDR_W-1:0] id_waddr;
  logic              id_is_load;
  logic [ADDR_W-1:0] id_raddr1;
  logic              id_rs1_used;
  logic [ADDR_W-1:0] id_raddr2;
  logic              id_rs2_used;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] mem_rdata;
  logic              ext_stall;
  logic              flush;

  logic              ex_we;
  logic [ADDR_W-1:0] ex_waddr;
  logic [DATA_W-1:0] ex_wdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_waddr;
  logic [DATA_W-1:0] wb_wdata;
  logic              lu_stall;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_we, id_waddr, id_is_load,
    output id_raddr1, id_rs1_used, id_raddr2, id_rs2_used,
    output ex_result, mem_rdata, ext_stall, flush,
    input  ex_we, ex_waddr, ex_wdata, mem_we, mem_waddr, mem_wdata,
    input  wb_we, wb_waddr, wb_wdata, lu_stall, stall_cnt
  );

  modport slave (
    input  id_valid, id_we, id_waddr, id_is_load,
    input  id_raddr1, id_rs1_used, id_raddr2, id_rs2_used,
    input  ex_result, mem_rdata, ext_stall, flush,
    output ex_we, ex_waddr, ex_wdata, mem_we, mem_waddr, mem_wdata,
    output wb_we, wb_waddr, wb_wdata, lu_stall, stall_cnt
  );
endinterface

// File: rtl/wb_fwd_pipe.sv
// Carries each instruction's destination bundle through EX/MEM/WB, drives the three
// forwarding buses and the register-file write port, and raises the load-use stall.
module wb_fwd_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  wb_fwd_if.slave   bus
);

  typedef struct packed {
    logic              we;
    logic              is_load;
    logic [ADDR_W-1:0] waddr;
  } ex_stage_t;

  typedef struct packed {
    logic              we;
    logic              is_load;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] data;
  } mem_stage_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] data;
  } wb_stage_t;

  ex_stage_t        ex_q;
  mem_stage_t       mem_q;
  wb_stage_t        wb_q;
  logic [CNT_W-1:0] cnt_q;

  logic              id_we_c;
  logic              rs1_hit_c;
  logic              rs2_hit_c;
  logic              lu_stall_c;
  logic [DATA_W-1:0] mem_wdata_c;

  // r0 writes are dropped at capture so they can never be forwarded or committed
  assign id_we_c = bus.id_valid & bus.id_we & (bus.id_waddr != '0);

  assign rs1_hit_c  = bus.id_rs1_used & (bus.id_raddr1 == ex_q.waddr);
  assign rs2_hit_c  = bus.id_rs2_used & (bus.id_raddr2 == ex_q.waddr);
  assign lu_stall_c = ex_q.we & ex_q.is_load & ~bus.ext_stall & bus.id_valid &
                      (rs1_hit_c | rs2_hit_c);

  assign mem_wdata_c = mem_q.is_load ? bus.mem_rdata : mem_q.data;

  // EX stage: flush and load-use both collapse into one bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (!bus.ext_stall) begin
      if (bus.flush || lu_stall_c) begin
        ex_q <= '0;
      end else begin
        ex_q.we      <= id_we_c;
        ex_q.is_load <= id_we_c & bus.id_is_load;
        ex_q.waddr   <= bus.id_waddr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else if (!bus.ext_stall) begin
      mem_q.we      <= ex_q.we;
      mem_q.is_load <= ex_q.is_load;
      mem_q.waddr   <= ex_q.waddr;
      mem_q.data    <= bus.ex_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else if (!bus.ext_stall) begin
      wb_q.we    <= mem_q.we;
      wb_q.waddr <= mem_q.waddr;
      wb_q.data  <= mem_wdata_c;
    end
  end

  // Saturating count of load-use bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (lu_stall_c && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A load's result does not exist in EX, so it is not offered on the EX bus
  assign bus.ex_we     = ex_q.we & ~ex_q.is_load;
  assign bus.ex_waddr  = ex_q.waddr;
  assign bus.ex_wdata  = rst_n ? bus.ex_result : '0;
  assign bus.mem_we    = mem_q.we;
  assign bus.mem_waddr = mem_q.waddr;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.wb_we     = wb_q.we;
  assign bus.wb_waddr  = wb_q.waddr;
  assign bus.wb_wdata  = wb_q.data;
  assign bus.lu_stall  = lu_stall_c;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_wb_fwd_pipe.sv
// Scoreboard bench for wb_fwd_pipe: commits expected at issue, popped when WB advances.
// A second instance with a 4-bit counter shadows the first to exercise saturation.
module tb_wb_fwd_pipe;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_fwd_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();
  wb_fwd_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(4))  bus4 ();

  wb_fwd_pipe #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  wb_fwd_pipe #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  assign bus4.id_valid    = bus.id_valid;
  assign bus4.id_we       = bus.id_we;
  assign bus4.id_waddr    = bus.id_waddr;
  assign bus4.id_is_load  = bus.id_is_load;
  assign bus4.id_raddr1   = bus.id_raddr1;
  assign bus4.id_rs1_used = bus.id_rs1_used;
  assign bus4.id_raddr2   = bus.id_raddr2;
  assign bus4.id_rs2_used = bus.id_rs2_used;
  assign bus4.ex_result   = bus.ex_result;
  assign bus4.mem_rdata   = bus.mem_rdata;
  assign bus4.ext_stall   = bus.ext_stall;
  assign bus4.flush       = bus.flush;

  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_stalls = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int a, input logic [DW-1:0] d);
    exp_t e;
    e.a = AW'(a);
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic drive_id(input logic v, input logic we, input int wa, input logic ld,
                          input int r1, input logic u1, input int r2, input logic u2);
    bus.id_valid    = v;
    bus.id_we       = we;
    bus.id_waddr    = AW'(wa);
    bus.id_is_load  = ld;
    bus.id_raddr1   = AW'(r1);
    bus.id_rs1_used = u1;
    bus.id_raddr2   = AW'(r2);
    bus.id_rs2_used = u2;
  endtask

  task automatic idle();
    drive_id(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  // One clock; afterwards a fresh WB entry (edge not frozen) must match the scoreboard head
  task automatic tick();
    logic frozen;
    exp_t e;
    frozen = bus.ext_stall;
    @(posedge clk);
    @(negedge clk);
    if (rst_n && !frozen && bus.wb_we) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", 64'(bus.wb_we), 64'(0));
      end else begin
        e = sb.pop_front();
        check("wb_commit", 64'({bus.wb_waddr, bus.wb_wdata}), 64'({e.a, e.d}));
      end
    end
  endtask

  task automatic check_fwd(input string tag,
                           input logic xw, input int xa, input logic [DW-1:0] xd,
                           input logic mw, input int ma, input logic [DW-1:0] md,
                           input logic ww, input int wa, input logic [DW-1:0] wd);
    check({tag, "_ex_we"},     64'(bus.ex_we),     64'(xw));
    check({tag, "_ex_waddr"},  64'(bus.ex_waddr),  64'(AW'(xa)));
    check({tag, "_ex_wdata"},  64'(bus.ex_wdata),  64'(xd));
    check({tag, "_mem_we"},    64'(bus.mem_we),    64'(mw));
    check({tag, "_mem_waddr"}, 64'(bus.mem_waddr), 64'(AW'(ma)));
    check({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'(md));
    check({tag, "_wb_we"},     64'(bus.wb_we),     64'(ww));
    check({tag, "_wb_waddr"},  64'(bus.wb_waddr),  64'(AW'(wa)));
    check({tag, "_wb_wdata"},  64'(bus.wb_wdata),  64'(wd));
  endtask

  task automatic check_zero(input string tag);
    check_fwd(tag, 1'b0, 0, '0, 1'b0, 0, '0, 1'b0, 0, '0);
    check({tag, "_lu_stall"},  64'(bus.lu_stall),  64'(0));
    check({tag, "_stall_cnt"}, 64'(bus.stall_cnt), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.ext_stall = 1'b0;
    bus.flush     = 1'b0;
    bus.ex_result = 32'hCAFE_F00D;
    bus.mem_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    bus.ex_result = '0;
    bus.mem_rdata = '0;

    // back-to-back ALU dependency
    drive_id(1, 1, 3, 0, 0, 0, 0, 0); push(3, 32'h11);
    #1 check("t1_lu_a", 64'(bus.lu_stall), 64'(0));
    tick();
    drive_id(1, 1, 4, 0, 3, 1, 0, 0); bus.ex_result = 32'h11; push(4, 32'h22);
    #1;
    check("t1_ex_we", 64'(bus.ex_we), 64'(1));
    check("t1_ex_waddr", 64'(bus.ex_waddr), 64'(3));
    check("t1_ex_wdata", 64'(bus.ex_wdata), 64'(32'h11));
    check("t1_lu_b", 64'(bus.lu_stall), 64'(0));
    tick();
    idle(); bus.ex_result = 32'h22;
    #1;
    check("t1_mem_waddr", 64'(bus.mem_waddr), 64'(3));
    check("t1_mem_wdata", 64'(bus.mem_wdata), 64'(32'h11));
    check("t1_ex_waddr2", 64'(bus.ex_waddr), 64'(4));
    tick();
    check("t1_wb_we", 64'(bus.wb_we), 64'(1));
    check("t1_wb_waddr", 64'(bus.wb_waddr), 64'(3));
    check("t1_wb_wdata", 64'(bus.wb_wdata), 64'(32'h11));
    tick(); tick();

    // load-use: one bubble, then the load is forwarded from MEM
    drive_id(1, 1, 5, 1, 0, 0, 0, 0); push(5, 32'hDEAD_BEEF);
    tick();
    drive_id(1, 1, 6, 0, 5, 1, 0, 0);
    #1;
    check("t2_lu", 64'(bus.lu_stall), 64'(1));
    check("t2_ex_we_load", 64'(bus.ex_we), 64'(0));
    tick(); exp_stalls++;
    bus.mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("t2_lu_clear", 64'(bus.lu_stall), 64'(0));
    check("t2_mem_we", 64'(bus.mem_we), 64'(1));
    check("t2_mem_waddr", 64'(bus.mem_waddr), 64'(5));
    check("t2_mem_wdata", 64'(bus.mem_wdata), 64'(32'hDEAD_BEEF));
    check("t2_stall_cnt", 64'(bus.stall_cnt), 64'(exp_stalls));
    check("t2_bubble", 64'(bus.ex_we), 64'(0));
    push(6, 32'h66);
    tick();
    idle(); bus.mem_rdata = '0; bus.ex_result = 32'h66;
    tick(); tick();

    // load followed by an instruction naming r5 without reading it
    drive_id(1, 1, 5, 1, 0, 0, 0, 0); push(5, 32'hA5A5_A5A5);
    tick();
    drive_id(1, 0, 7, 0, 5, 0, 5, 0);
    #1 check("t3_lu_unused", 64'(bus.lu_stall), 64'(0));
    tick();
    idle(); bus.mem_rdata = 32'hA5A5_A5A5;
    tick();
    bus.mem_rdata = '0;

    // r0 destination is never forwarded or committed
    drive_id(1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    idle(); bus.ex_result = 32'h99;
    #1 check("t3_r0_ex", 64'(bus.ex_we), 64'(0));
    tick();
    check("t3_r0_mem", 64'(bus.mem_we), 64'(0));
    tick();
    check("t3_r0_wb", 64'(bus.wb_we), 64'(0));
    tick();

    // ext_stall with a full pipe; flush during the freeze must be ignored
    drive_id(1, 1, 1, 0, 0, 0, 0, 0); push(1, 32'h101);
    tick();
    drive_id(1, 1, 2, 0, 0, 0, 0, 0); bus.ex_result = 32'h101; push(2, 32'h102);
    tick();
    drive_id(1, 1, 3, 0, 0, 0, 0, 0); bus.ex_result = 32'h102; push(3, 32'h103);
    tick();
    drive_id(1, 1, 9, 0, 0, 0, 0, 0); bus.ex_result = 32'h103; bus.ext_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.flush = (k == 1);
      tick();
      #1;
      check_fwd($sformatf("t4_hold%0d", k), 1, 3, 32'h103, 1, 2, 32'h102, 1, 1, 32'h101);
      check("t4_lu", 64'(bus.lu_stall), 64'(0));
    end
    bus.ext_stall = 1'b0; bus.flush = 1'b0; push(9, 32'h109);
    tick();
    check("t4_adv_ex", 64'(bus.ex_waddr), 64'(9));
    check("t4_adv_mem_a", 64'(bus.mem_waddr), 64'(3));
    check("t4_adv_mem_d", 64'(bus.mem_wdata), 64'(32'h103));
    check("t4_adv_wb", 64'(bus.wb_waddr), 64'(2));
    idle(); bus.ex_result = 32'h109;
    tick(); tick();

    // flush kills the instruction entering EX
    drive_id(1, 1, 7, 0, 0, 0, 0, 0); bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; idle(); bus.ex_result = 32'h55;
    #1 check("t5_ex_we", 64'(bus.ex_we), 64'(0));
    tick();
    check("t5_mem_we", 64'(bus.mem_we), 64'(0));
    tick();
    check("t5_wb_we", 64'(bus.wb_we), 64'(0));
    tick();

    // flush coinciding with load-use yields a single bubble
    drive_id(1, 1, 5, 1, 0, 0, 0, 0); push(5, 32'h5A5A_0000);
    tick();
    drive_id(1, 1, 6, 0, 0, 0, 5, 1); bus.flush = 1'b1;
    #1 check("t5_lu_flush", 64'(bus.lu_stall), 64'(1));
    tick(); exp_stalls++;
    bus.flush = 1'b0; idle(); bus.mem_rdata = 32'h5A5A_0000;
    #1;
    check("t5_bubble", 64'(bus.ex_we), 64'(0));
    check("t5_stall_cnt", 64'(bus.stall_cnt), 64'(exp_stalls));
    tick();
    bus.mem_rdata = '0;
    tick(); tick();

    // repeated load-use pairs; the 4-bit shadow counter must pin at 15
    for (int i = 0; i < 18; i++) begin
      drive_id(1, 1, 5, 1, 0, 0, 0, 0); push(5, 32'h100 + i);
      tick();
      drive_id(1, 0, 0, 0, 5, 1, 0, 0);
      #1 check($sformatf("t6_lu%0d", i), 64'(bus.lu_stall), 64'(1));
      tick(); exp_stalls++;
      bus.mem_rdata = 32'h100 + i;
      tick();
      bus.mem_rdata = '0;
      check($sformatf("t6_cnt%0d", i), 64'(bus.stall_cnt), 64'(exp_stalls));
      check($sformatf("t6_sat%0d", i), 64'(bus4.stall_cnt),
            64'((exp_stalls > 15) ? 15 : exp_stalls));
    end
    idle();
    tick(); tick(); tick();

    // asynchronous reset mid-cycle with a full pipe
    drive_id(1, 1, 1, 0, 0, 0, 0, 0); push(1, 32'h201);
    tick();
    drive_id(1, 1, 2, 0, 0, 0, 0, 0); bus.ex_result = 32'h201; push(2, 32'h202);
    tick();
    drive_id(1, 1, 3, 0, 0, 0, 0, 0); bus.ex_result = 32'h202; push(3, 32'h203);
    tick();
    drive_id(1, 1, 4, 0, 0, 0, 0, 0); bus.ex_result = 32'h203;
    #2 rst_n = 1'b0;
    #1 check_zero("t7_rst");
    check("t7_rst_cnt4", 64'(bus4.stall_cnt), 64'(0));
    sb.delete();
    exp_stalls = 0;
    tick();
    idle(); bus.ex_result = '0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("t7_wb_quiet%0d", k), 64'(bus.wb_we), 64'(0));
    end
    check("t7_cnt_after", 64'(bus.stall_cnt), 64'(0));

    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_fwd_pipe.md
Name: wb_fwd_pipe

Overview:
Writer side of the register-file bypass interface. Carries each instruction's destination bundle (we, waddr, wdata) through the EX, MEM and WB stage registers. Drives the three forwarding buses and the architectural write port consumed by the register file. Generates the load-use stall, which is required because load data does not exist until MEM.

Parameters:
DATA_W, 32, width of write data and results
ADDR_W, 5, width of register address; address 0 is the hard-wired zero register
CNT_W, 32, width of the saturating stall-event counter

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a valid instruction
id_we  in  1  instruction writes a register
id_waddr  in  ADDR_W  destination register
id_is_load  in  1  instruction is a load (result comes from memory)
id_raddr1  in  ADDR_W  source 1 of instruction in ID
id_rs1_used  in  1  source 1 is actually read
id_raddr2  in  ADDR_W  source 2 of instruction in ID
id_rs2_used  in  1  source 2 is actually read
ex_result  in  DATA_W  ALU result of instruction currently in EX (combinational)
mem_rdata  in  DATA_W  load data for instruction currently in MEM (combinational)
ext_stall  in  1  freeze entire pipe (memory wait)
flush  in  1  kill instruction entering EX (branch redirect)
ex_we  out  1  EX forward enable
ex_waddr  out  ADDR_W  EX forward address
ex_wdata  out  DATA_W  EX forward data
mem_we  out  1  MEM forward enable
mem_waddr  out  ADDR_W  MEM forward address
mem_wdata  out  DATA_W  MEM forward data
wb_we  out  1  register-file write enable / WB forward enable
wb_waddr  out  ADDR_W  write address
wb_wdata  out  DATA_W  write data
lu_stall  out  1  load-use stall request to fetch/decode
stall_cnt  out  CNT_W  count of cycles with lu_stall=1

Behaviour:
- Reset (async, rst_n=0): all stage valid/we bits 0, addresses 0, data 0, stall_cnt 0. Every output reads 0 while in reset, including lu_stall.
- Capture rule: a stage's we is stored as valid & we & (waddr != 0). A write to r0 is never forwarded or committed.
- EX register, on each clock edge:
  - ext_stall=1: hold.
  - Otherwise flush=1 or lu_stall=1: load a bubble (we=0, is_load=0).
  - Otherwise: load the ID bundle.
- MEM register:
  - ext_stall=1: hold.
  - Otherwise: load the EX bundle, with data = ex_result.
- WB register:
  - ext_stall=1: hold.
  - Otherwise: load the MEM bundle, with data = mem_wdata.
- Forwarding outputs:
  - ex_we = EX.we & ~EX.is_load; ex_wdata = ex_result. A load's data is not available in EX.
  - mem_we = MEM.we; mem_wdata = MEM.is_load ? mem_rdata : MEM.data.
  - wb_* come directly from WB register outputs.
- Latency: an instruction accepted at edge N is on ex_* during cycle N..N+1. It reaches mem_* one edge later and wb_* one edge after that. The register file commits it at the following edge.
- lu_stall (combinational) = EX.we & EX.is_load & ~ext_stall & ((id_rs1_used & id_raddr1==EX.waddr) | (id_rs2_used & id_raddr2==EX.waddr)) & id_valid.
  - Exactly one bubble per load-use pair. The next cycle the load is in MEM, where mem_wdata supplies it.
- Priority: rst_n > ext_stall > flush > lu_stall > normal.
  - flush while ext_stall=1 is ignored; the upstream logic holds flush until the stall clears.
  - flush and lu_stall together produce a single bubble.
- stall_cnt: increments on each edge where lu_stall=1 and saturates at all-ones. It is never cleared except by reset.
- Reset asserted mid-operation discards all in-flight bundles; no write occurs on the reset edge.

Test Plan:
- Back-to-back ALU: ID r3←(ex_result 0x11), then r4 reading r3 → next cycle ex_we=1, ex_waddr=3, ex_wdata=0x11, lu_stall=0. Three edges later wb_we=1, wb_waddr=3, wb_wdata=0x11.
- Load-use: EX holds load r5, ID reads r5 (rs1_used=1) → lu_stall=1 for exactly 1 cycle and ex_we=0. Next cycle mem_we=1, mem_waddr=5, mem_wdata=mem_rdata=0xDEADBEEF, lu_stall=0, stall_cnt=1.
- Load with source unused: EX load r5, ID raddr1=5 but rs1_used=0 → lu_stall=0. Separately, ID writes r0 → ex_we, mem_we, wb_we all stay 0 through WB.
- ext_stall held 3 cycles with the pipe full (r1, r2, r3) → all nine forwarding outputs are unchanged for all 3 cycles. After release, values advance one stage per edge. Also assert flush during the stall → it has no effect.
- flush with valid ID r7 (0x55) → EX becomes a bubble (ex_we=0), and r7 never appears on mem_* or wb_*.
- Reset pulse (rst_n=0, asynchronous, mid-cycle) with the pipe full → all outputs 0 immediately. After release with id_valid=0, wb_we stays 0. Also: force stall_cnt to near-saturation → it stops at 0xFFFFFFFF.
